// File: rtl/pool2d_stream.sv
// Streaming KxK non-overlapping pooling over raster-order pixels, CH signed channels per beat.
// Optional average pooling with an i_mode port is enabled by defining POOL2D_AVG_EN.
module pool2d_stream #(
    parameter int unsigned CH    = 48,
    parameter int unsigned IN_BW = 32,
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8,
    parameter int unsigned K     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef POOL2D_AVG_EN
    input  logic                  i_mode,
`endif
    input  logic                  i_in_valid,
    input  logic                  i_sof,
    input  logic [CH*IN_BW-1:0]   i_in_pixel,
    output logic                  o_ot_valid,
    output logic [CH*IN_BW-1:0]   o_ot_pool,
    output logic                  o_frame_done,
    output logic                  o_sync_err
);

    localparam int unsigned LOGK = $clog2(K);
    localparam int unsigned NB   = IMG_W / K;
    localparam int unsigned NBR  = IMG_H / K;
`ifdef POOL2D_AVG_EN
    localparam int unsigned PW   = IN_BW + 2 * LOGK;
`else
    localparam int unsigned PW   = IN_BW;
`endif
    localparam int unsigned CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned BW   = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [CW-1:0]   COL_LAST    = CW'(IMG_W - 1);
    localparam logic [RW-1:0]   ROW_LAST    = RW'(IMG_H - 1);
    localparam logic [CW-1:0]   COL_WIN_END = CW'(NB * K - 1);
    localparam logic [RW-1:0]   ROW_WIN_END = RW'(NBR * K - 1);
    localparam logic [LOGK-1:0] SUB_LAST    = LOGK'(K - 1);

    logic [CW-1:0]         col_q, col_d, eff_col;
    logic [RW-1:0]         row_q, row_d, eff_row;
    logic                  valid_q, valid_d;
    logic [CH*IN_BW-1:0]   pool_q, pool_d, pool_res;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  mode_eff;
`ifdef POOL2D_AVG_EN
    logic                  mode_q, mode_d;
`endif

    logic [CH*PW-1:0]      part_q [NB];
    logic [CH*PW-1:0]      part_rd, part_wdata;
    logic [CW-1:0]         bucket_full;
    logic [BW-1:0]         bidx;
    logic                  in_window, first, last, part_we;

    logic signed [IN_BW-1:0] pix;
    logic signed [PW-1:0]    ext, old, res;

    // A sof beat always lands at (0,0), whether or not the counters agree.
    always_comb begin
        eff_col     = i_sof ? '0 : col_q;
        eff_row     = i_sof ? '0 : row_q;
        bucket_full = eff_col >> LOGK;
        bidx        = BW'(bucket_full);
        in_window   = (32'(eff_col) < NB * K) && (32'(eff_row) < NBR * K);
        first       = (eff_col[LOGK-1:0] == '0) && (eff_row[LOGK-1:0] == '0);
        last        = (eff_col[LOGK-1:0] == SUB_LAST) && (eff_row[LOGK-1:0] == SUB_LAST);
        part_we     = i_in_valid && in_window && !reset;
        part_rd     = part_q[bidx];
`ifdef POOL2D_AVG_EN
        mode_eff    = (eff_col == '0 && eff_row == '0) ? i_mode : mode_q;
        mode_d      = i_in_valid ? mode_eff : mode_q;
`else
        mode_eff    = 1'b0;
`endif
    end

    always_comb begin
        part_wdata = '0;
        pool_res   = '0;
        pix        = '0;
        ext        = '0;
        old        = '0;
        res        = '0;
        for (int c = 0; c < CH; c++) begin
            pix = i_in_pixel[c*IN_BW +: IN_BW];
            ext = PW'(pix);
            old = part_rd[c*PW +: PW];
            if (first) begin
                res = ext;
            end else if (mode_eff) begin
                res = old + ext;
            end else begin
                // Strict compare keeps the earlier value on a tie.
                res = (ext > old) ? ext : old;
            end
            part_wdata[c*PW +: PW] = res;
`ifdef POOL2D_AVG_EN
            pool_res[c*IN_BW +: IN_BW] = mode_eff ? IN_BW'(res >>> (2 * LOGK)) : IN_BW'(res);
`else
            pool_res[c*IN_BW +: IN_BW] = res;
`endif
        end
    end

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        pool_d  = pool_q;
        if (i_in_valid) begin
            err_d = i_sof && ((col_q != '0) || (row_q != '0));
            if (eff_col == COL_LAST) begin
                col_d = '0;
                row_d = (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
            end else begin
                col_d = eff_col + 1'b1;
                row_d = eff_row;
            end
            if (in_window && last) begin
                valid_d = 1'b1;
                pool_d  = pool_res;
                done_d  = (eff_col == COL_WIN_END) && (eff_row == ROW_WIN_END);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            pool_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef POOL2D_AVG_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            pool_q  <= pool_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef POOL2D_AVG_EN
            mode_q  <= mode_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (part_we) begin
            part_q[bidx] <= part_wdata;
        end
    end

    assign o_ot_valid   = valid_q;
    assign o_ot_pool    = pool_q;
    assign o_frame_done = done_q;
    assign o_sync_err   = err_q;

endmodule

// File: tb/tb_pool2d_stream.sv
// Directed bench for pool2d_stream on a 4x4, K=2, two-channel, 16-bit configuration.
// Average-mode steps are included only when POOL2D_AVG_EN is defined.
module tb_pool2d_stream;

    localparam int unsigned CH    = 2;
    localparam int unsigned IN_BW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_in_valid;
    logic              i_sof;
    logic [CH*IN_BW-1:0] i_in_pixel;
    logic              o_ot_valid;
    logic [CH*IN_BW-1:0] o_ot_pool;
    logic              o_frame_done;
    logic              o_sync_err;
`ifdef POOL2D_AVG_EN
    logic              i_mode;
`endif

    int errors = 0;
    int checks = 0;
    logic [15:0] hold0 = '0;
    logic [15:0] hold1 = '0;

    pool2d_stream #(
        .CH(CH), .IN_BW(IN_BW), .IMG_W(4), .IMG_H(4), .K(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef POOL2D_AVG_EN
        .i_mode       (i_mode),
`endif
        .i_in_valid   (i_in_valid),
        .i_sof        (i_sof),
        .i_in_pixel   (i_in_pixel),
        .o_ot_valid   (o_ot_valid),
        .o_ot_pool    (o_ot_pool),
        .o_frame_done (o_frame_done),
        .o_sync_err   (o_sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one valid beat, then check the registered outputs 1 ns after the edge.
    task automatic beat(input logic [15:0] p0, input logic [15:0] p1, input logic sof,
                        input logic ev, input logic [15:0] e0, input logic [15:0] e1,
                        input logic ed, input logic ee);
        i_in_valid = 1'b1;
        i_sof      = sof;
        i_in_pixel = {p1, p0};
        @(posedge clk);
        #1;
        if (ev) begin
            hold0 = e0;
            hold1 = e1;
        end
        chk("valid", {15'd0, o_ot_valid}, {15'd0, ev});
        chk("pool_ch0", o_ot_pool[15:0], hold0);
        chk("pool_ch1", o_ot_pool[31:16], hold1);
        chk("frame_done", {15'd0, o_frame_done}, {15'd0, ed});
        chk("sync_err", {15'd0, o_sync_err}, {15'd0, ee});
        i_in_valid = 1'b0;
        i_sof      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            i_in_valid = 1'b0;
            i_sof      = $urandom_range(0, 1) == 1;
            i_in_pixel = $urandom;
            @(posedge clk);
            #1;
            chk("idle_valid", {15'd0, o_ot_valid}, 16'd0);
            chk("idle_hold0", o_ot_pool[15:0], hold0);
        end
        i_sof = 1'b0;
    endtask

    // Ramp frame: ch0 = i, ch1 = -i; window maxima are bottom-right ch0 and top-left ch1.
    task automatic ramp_frame(input logic sof0, input logic err0, input int max_gap);
        for (int i = 0; i < 16; i++) begin
            logic ev;
            logic [15:0] v, e1;
            ev = (i == 5) || (i == 7) || (i == 13) || (i == 15);
            v  = 16'(i);
            e1 = (i == 5) ? 16'd0 : (i == 7) ? -16'sd2 : (i == 13) ? -16'sd8 : -16'sd10;
            beat(v, -v, sof0 && (i == 0), ev, v, e1, i == 15, err0 && (i == 0));
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    initial begin
        reset      = 1'b1;
        i_in_valid = 1'b1;
        i_sof      = 1'b1;
        i_in_pixel = 32'hdead_beef;
`ifdef POOL2D_AVG_EN
        i_mode     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {15'd0, o_ot_valid}, 16'd0);
        chk("rst_pool", o_ot_pool[15:0] | o_ot_pool[31:16], 16'd0);
        chk("rst_done", {15'd0, o_frame_done}, 16'd0);
        chk("rst_err", {15'd0, o_sync_err}, 16'd0);
        reset      = 1'b0;
        i_in_valid = 1'b0;
        i_sof      = 1'b0;

        // Plain ramp frame, back-to-back.
        ramp_frame(1'b1, 1'b0, 0);

        // Signed frame right after: window 0 ch0 {-3,-1,-8,-2}, ch1 all -5 (ties).
        for (int i = 0; i < 16; i++) begin
            logic [15:0] p0;
            logic ev;
            p0 = (i == 0) ? -16'sd3 : (i == 1) ? -16'sd1 : (i == 4) ? -16'sd8 :
                 (i == 5) ? -16'sd2 : 16'd0;
            ev = (i == 5) || (i == 7) || (i == 13) || (i == 15);
            beat(p0, -16'sd5, i == 0, ev, (i == 5) ? -16'sd1 : 16'd0, -16'sd5, i == 15, 1'b0);
        end

        // Ramp frame with random gaps; stray sof during idle must be ignored.
        ramp_frame(1'b1, 1'b0, 3);

        // Mid-frame sof on pixel 6 restarts the stream at that pixel.
        for (int i = 0; i < 6; i++) begin
            logic [15:0] v;
            v = 16'(i);
            beat(v, -v, i == 0, i == 5, v, 16'd0, 1'b0, 1'b0);
        end
        ramp_frame(1'b1, 1'b1, 0);

        // Reset in place of pixel 9, then a fresh frame without sof.
        for (int i = 0; i < 9; i++) begin
            logic [15:0] v;
            v = 16'(i);
            beat(v, -v, i == 0, (i == 5) || (i == 7), v,
                 (i == 7) ? -16'sd2 : 16'd0, 1'b0, 1'b0);
        end
        reset      = 1'b1;
        i_in_valid = 1'b1;
        i_sof      = 1'b1;
        i_in_pixel = 32'h7fff_7fff;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("mid_rst_valid", {15'd0, o_ot_valid}, 16'd0);
            chk("mid_rst_pool", o_ot_pool[15:0] | o_ot_pool[31:16], 16'd0);
            chk("mid_rst_flags", {14'd0, o_frame_done, o_sync_err}, 16'd0);
        end
        reset      = 1'b0;
        i_in_valid = 1'b0;
        i_sof      = 1'b0;
        hold0      = '0;
        hold1      = '0;
        ramp_frame(1'b0, 1'b0, 0);
        idle(2);

`ifdef POOL2D_AVG_EN
        // Average mode: ch0 {-3,-2,-2,-2} -> -3 (floor of -2.25), ch1 {1,2,3,4} -> 2.
        i_mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] p0, p1;
            logic ev;
            p0 = (i == 0) ? -16'sd3 : ((i == 1) || (i == 4) || (i == 5)) ? -16'sd2 : 16'd0;
            p1 = (i == 0) ? 16'd1 : (i == 1) ? 16'd2 : (i == 4) ? 16'd3 :
                 (i == 5) ? 16'd4 : 16'd0;
            ev = (i == 5) || (i == 7) || (i == 13) || (i == 15);
            beat(p0, p1, i == 0, ev, (i == 5) ? -16'sd3 : 16'd0,
                 (i == 5) ? 16'd2 : 16'd0, i == 15, 1'b0);
            i_mode = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pool2d_stream.md
Name: pool2d_stream

Overview:
- Streaming 2-D pooling for CNN stage outputs. Non-overlapping KxK window, stride K, CH channels packed per beat.
- Sits after the ReLU/activation stage and ahead of flatten/FC.
- Input pixels arrive in raster order. Per-column partial reductions are kept in a buffer of IMG_W/K entries, so no full line buffer is needed.
- Generalises 2x2 max pooling to parametric K, width, height and channel count, adds frame sync and error flagging, and optionally supports average pooling.

Parameters:
- CH, 48, channels per beat
- IN_BW, 32, signed pixel width; output width equals IN_BW
- IMG_W, 8, input columns per row
- IMG_H, 8, input rows per frame
- K, 2, pool window and stride; power of two, 2..8

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_in_valid  in  1  input beat valid; no backpressure
- i_sof  in  1  start of frame; sampled only when i_in_valid=1
- i_in_pixel  in  CH*IN_BW  channel c at [c*IN_BW +: IN_BW], signed
- o_ot_valid  out  1  pooled beat valid
- o_ot_pool  out  CH*IN_BW  pooled result, same packing as input
- o_frame_done  out  1  pulses with the last pooled beat of a frame
- o_sync_err  out  1  1-cycle pulse: i_sof arrived mid-frame

Behaviour:
- Reset: reset=1 at a clk edge clears col/row counters, o_ot_valid, o_ot_pool, o_frame_done and o_sync_err to 0. Reset overrides all other inputs. Partial buffer contents need not be cleared.
- Reset mid-frame: the in-progress frame is discarded. The next accepted pixel is treated as (row 0, col 0).
- Counters: col counts 0..IMG_W-1 and row counts 0..IMG_H-1. Both advance only on i_in_valid=1.
  - At col=IMG_W-1: col wraps to 0 and row increments.
  - At the last pixel of the frame (col=IMG_W-1, row=IMG_H-1): both wrap to 0.
- Window position: bucket index b = col/K; sub-position is (row%K, col%K).
- First pixel of a window (row%K=0, col%K=0): partial[b] is overwritten with the pixel.
- Every other pixel: partial[b] = op(partial[b], pixel), independently per channel.
- Max op: signed compare. On a tie the earlier value is kept.
- Window completion: when row%K=K-1 and col%K=K-1, op(partial[b], pixel) is registered into o_ot_pool and o_ot_valid=1 on the next cycle. Latency is 1 clk from the completing input beat.
- Output holds: o_ot_pool keeps its value between valid pulses. o_ot_valid is a 1-cycle pulse per completed window.
- Beats per frame: (IMG_W/K)*(IMG_H/K) pooled beats, in raster order of windows.
- Non-multiple sizes (floor mode): if IMG_W or IMG_H is not a multiple of K, remainder columns/rows are accepted and counted but never produce output. Their partials are not written.
- o_frame_done: asserted in the same cycle as o_ot_valid for the window whose bottom-right pixel is at row K*(IMG_H/K)-1, col K*(IMG_W/K)-1.
- i_sof with i_in_valid=1 at counters (0,0): normal, no error.
- i_sof with i_in_valid=1 at counters not (0,0):
  - o_sync_err pulses on the next cycle.
  - The pixel is processed as (row 0, col 0) and counters continue from there.
  - Partials of the aborted frame are discarded and no output is produced for them.
- i_sof with i_in_valid=0: ignored.
- Gaps: idle cycles between valid beats are allowed anywhere and change no state.
- Back-to-back: one beat per cycle sustained, at full throughput.

Optional Feature:
- Macro: POOL2D_AVG_EN.
- Defined:
  - Adds input port i_mode (1 bit; 0=max, 1=avg). i_mode is sampled at the first pixel of each frame and held for that frame.
  - Avg mode accumulates in IN_BW+2*log2(K) signed bits.
  - Output = accumulated sum arithmetically shifted right by 2*log2(K), i.e. floor toward -inf, truncated to IN_BW bits.
  - The partial buffer is widened accordingly.
- Undefined: no i_mode port, max-only, partial buffer is IN_BW bits wide.

Test Plan:
- Max, CH=1, K=2, IMG_W=IMG_H=4. Pixels 0..15 in raster order, sof on pixel 0 -> 4 beats: 5, 7, 13, 15.
  - Each beat arrives 1 clk after input pixels 5, 7, 13 and 15 respectively.
  - o_frame_done is high with 15.
- Signed max, CH=2. Window values ch0={-3,-1,-8,-2} and ch1={-5,-5,-5,-5} -> ch0=-1, ch1=-5.
- Gaps and back-to-back: repeat the first test with random idle cycles inserted -> identical outputs and order. The next frame immediately follows with no sync_err.
- Mid-frame sof: assert sof on pixel 6 of a 4x4 frame -> o_sync_err pulses 1 clk later.
  - The stream restarts from that pixel.
  - The next 16 pixels produce exactly 4 outputs.
- Reset at pixel 9, then a fresh frame of 16 pixels -> all outputs 0 during reset and exactly 4 correct pooled beats after.
- POOL2D_AVG_EN, i_mode=1, K=2, window {-3,-2,-2,-2} -> sum -9, output -3 (floor). Window {1,2,3,4} -> 2.
